// File: rtl/hamm_seq_if.sv
// Request/result handshake bundle for the sequential Hamming weight/distance engine.
interface hamm_seq_if #(
    parameter int DATA_W = 32
) ();
    localparam int RES_W = $clog2(DATA_W + 1);

    logic              in_valid;
    logic              in_ready;
    logic              mode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  res;
    logic              parity;
    logic              busy;

    modport master (
        output in_valid, mode, a, b, out_ready,
        input  in_ready, out_valid, res, parity, busy
    );

    modport slave (
        input  in_valid, mode, a, b, out_ready,
        output in_ready, out_valid, res, parity, busy
    );
endinterface

// File: rtl/hamm_seq_unit.sv
// Multi-cycle popcount / Hamming-distance engine: counts CHUNK_W bits per cycle over a latched operand.
//   state | meaning
//   IDLE  | waiting for a request, in_ready high
//   RUN   | summing one chunk per cycle, LSB chunk first
//   DONE  | result held on res/parity until out_ready
module hamm_seq_unit #(
    parameter int DATA_W  = 32,
    parameter int CHUNK_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    hamm_seq_if.slave  bus
);
    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int RES_W  = $clog2(DATA_W + 1);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  op;
    logic [RES_W-1:0]   acc;
    logic [IDX_W-1:0]   idx;

    function automatic logic [RES_W-1:0] chunk_ones(input logic [CHUNK_W-1:0] v);
        logic [RES_W-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            n = n + RES_W'(v[i]);
        end
        return n;
    endfunction

    // The operand shifts right each RUN cycle so the active chunk is always the low CHUNK_W bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op    <= '0;
            acc   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op    <= bus.mode ? (bus.a ^ bus.b) : bus.a;
                        acc   <= '0;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc + chunk_ones(op[CHUNK_W-1:0]);
                    op  <= op >> CHUNK_W;
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == RUN) || (state == DONE);
    assign bus.res       = acc;
    assign bus.parity    = acc[0];
endmodule

// File: tb/tb_hamm_seq_unit.sv
// Randomized bench for hamm_seq_unit: a 32/8 and a 64/16 instance checked against $countones.
module tb_hamm_seq_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hamm_seq_if #(.DATA_W(32)) bus32 ();
    hamm_seq_if #(.DATA_W(64)) bus64 ();

    hamm_seq_unit #(.DATA_W(32), .CHUNK_W(8))  u32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    hamm_seq_unit #(.DATA_W(64), .CHUNK_W(16)) u64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic        mode = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;

    assign bus32.in_valid  = in_valid & ~sel;
    assign bus32.mode      = mode;
    assign bus32.a         = a[31:0];
    assign bus32.b         = b[31:0];
    assign bus32.out_ready = out_ready;
    assign bus64.in_valid  = in_valid & sel;
    assign bus64.mode      = mode;
    assign bus64.a         = a;
    assign bus64.b         = b;
    assign bus64.out_ready = out_ready;

    wire [6:0] o_res       = sel ? bus64.res : {1'b0, bus32.res};
    wire       o_parity    = sel ? bus64.parity : bus32.parity;
    wire       o_in_ready  = sel ? bus64.in_ready : bus32.in_ready;
    wire       o_out_valid = sel ? bus64.out_valid : bus32.out_valid;
    wire       o_busy      = sel ? bus64.busy : bus32.busy;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic int model(input logic s, input logic m, input logic [63:0] av, input logic [63:0] bv);
        logic [63:0] x;
        x = m ? (av ^ bv) : av;
        if (!s) x[63:32] = '0;
        return $countones(x);
    endfunction

    // One complete request/result transaction, holding the result 'hold' cycles before the handshake.
    task automatic do_op(input string name, input logic s, input logic m, input logic [63:0] av,
                         input logic [63:0] bv, input int hold, input logic junk_valid);
        int exp;
        int cyc;
        exp = model(s, m, av, bv);
        sel = s;
        out_ready = 1'b0;
        vectors++;
        if (o_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s idle_ready: got %b want 1", name, o_in_ready);
        end
        in_valid = 1'b1; mode = m; a = av; b = bv;
        @(negedge clk);
        in_valid = 1'b0; mode = $urandom_range(0, 1); a = rand64(); b = rand64();
        cyc = 0;
        while (o_out_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (cyc != 4) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want 4", name, cyc);
        end
        vectors++;
        if (o_res !== 7'(exp) || o_parity !== exp[0]) begin
            miscompares++;
            $display("FAIL %s result: got res=%0d par=%b want res=%0d par=%b", name, o_res, o_parity, exp, exp[0]);
        end
        vectors++;
        if (o_busy !== 1'b1 || o_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_flags: got busy=%b ready=%b want busy=1 ready=0", name, o_busy, o_in_ready);
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = junk_valid; mode = $urandom_range(0, 1); a = rand64(); b = rand64();
            @(negedge clk);
            vectors++;
            if (o_out_valid !== 1'b1 || o_res !== 7'(exp) || o_in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL %s hold%0d: got v=%b res=%0d rdy=%b want v=1 res=%0d rdy=0",
                         name, i, o_out_valid, o_res, o_in_ready, exp);
            end
        end
        in_valid = junk_valid;
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s release: got v=%b rdy=%b busy=%b want v=0 rdy=1 busy=0",
                     name, o_out_valid, o_in_ready, o_busy);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0 || bus32.busy !== 1'b0 ||
            bus32.res !== 6'd0 || bus32.parity !== 1'b0) begin
            miscompares++;
            $display("FAIL reset32: got rdy=%b v=%b busy=%b res=%0d par=%b want 1 0 0 0 0",
                     bus32.in_ready, bus32.out_valid, bus32.busy, bus32.res, bus32.parity);
        end
        vectors++;
        if (bus64.in_ready !== 1'b1 || bus64.out_valid !== 1'b0 || bus64.busy !== 1'b0 ||
            bus64.res !== 7'd0 || bus64.parity !== 1'b0) begin
            miscompares++;
            $display("FAIL reset64: got rdy=%b v=%b busy=%b res=%0d par=%b want 1 0 0 0 0",
                     bus64.in_ready, bus64.out_valid, bus64.busy, bus64.res, bus64.parity);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_popcount();
        do_op("pop_ones",  1'b0, 1'b0, 64'hFFFF_FFFF, 64'h0, 0, 1'b0);
        do_op("pop_ends",  1'b0, 1'b0, 64'h8000_0001, 64'hFFFF_FFFF, 0, 1'b0);
        do_op("pop_bit7",  1'b0, 1'b0, 64'h0000_0080, 64'h0, 0, 1'b0);
        do_op("pop_zero",  1'b0, 1'b0, 64'h0, 64'hFFFF_FFFF, 0, 1'b0);
        for (int i = 0; i < 150; i++) begin
            do_op("pop_rand32", 1'b0, 1'($urandom_range(0, 1)), rand64(), rand64(), $urandom_range(0, 2), 1'b0);
        end
    endtask

    task automatic test_distance();
        do_op("dist_comp", 1'b0, 1'b1, 64'hA5A5_A5A5, 64'h5A5A_5A5A, 0, 1'b0);
        do_op("dist_same", 1'b0, 1'b1, 64'h1234_5678, 64'h1234_5678, 0, 1'b0);
    endtask

    task automatic test_done_hold();
        do_op("done_hold", 1'b0, 1'b0, 64'h0F0F_00F1, 64'h0, 10, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        sel = 1'b0;
        in_valid = 1'b1; mode = 1'b0; a = 64'hFFFF_FFFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0 || bus32.busy !== 1'b0 || bus32.res !== 6'd0) begin
            miscompares++;
            $display("FAIL rst_mid_run: got rdy=%b v=%b busy=%b res=%0d want 1 0 0 0",
                     bus32.in_ready, bus32.out_valid, bus32.busy, bus32.res);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL rst_no_pulse%0d: got v=%b rdy=%b want v=0 rdy=1", i, bus32.out_valid, bus32.in_ready);
            end
        end
        do_op("after_rst", 1'b0, 1'b0, 64'h0000_000F, 64'h0, 0, 1'b0);
    endtask

    // out_ready and in_valid held high: one op every NCHUNK+2 = 6 cycles, results in order.
    task automatic test_back_to_back();
        int q[$];
        int last_acc;
        int exp;
        sel = 1'b0;
        out_ready = 1'b1;
        last_acc = -1;
        for (int n = 0; n < 72; n++) begin
            if (o_out_valid === 1'b1) begin
                exp = (q.size() > 0) ? q.pop_front() : -1;
                vectors++;
                if (o_res !== 7'(exp)) begin
                    miscompares++;
                    $display("FAIL b2b_result: got %0d want %0d", o_res, exp);
                end
            end
            if (o_in_ready === 1'b1) begin
                if (last_acc >= 0) begin
                    vectors++;
                    if (n - last_acc != 6) begin
                        miscompares++;
                        $display("FAIL b2b_spacing: got %0d want 6", n - last_acc);
                    end
                end
                last_acc = n;
            end
            in_valid = 1'b1; mode = $urandom_range(0, 1); a = rand64(); b = rand64();
            if (o_in_ready === 1'b1) q.push_back(model(1'b0, mode, a, b));
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (o_out_valid === 1'b1) begin
                exp = (q.size() > 0) ? q.pop_front() : -1;
                vectors++;
                if (o_res !== 7'(exp)) begin
                    miscompares++;
                    $display("FAIL b2b_drain: got %0d want %0d", o_res, exp);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_lost: got %0d pending want 0", q.size());
        end
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wide();
        do_op("wide_ones", 1'b1, 1'b0, '1, '0, 0, 1'b0);
        do_op("wide_dist", 1'b1, 1'b1, 64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 0, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            do_op("wide_rand", 1'b1, 1'($urandom_range(0, 1)), rand64(), rand64(), 0, 1'($urandom_range(0, 1)));
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_popcount();
        test_distance();
        test_done_hold();
        test_reset_mid_run();
        test_back_to_back();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
